id_hazard_controller: RTL
=========================

// Module: id_hazard_controller
// PURPOSE
//  Sequences the ID stage around the immediate-extension / branch-compare path:
//  - detects load-use and branch-operand hazards on the instruction held in IF/ID;
//  - stalls PC and IF/ID, and inserts a bubble into ID/EX;
//  - flushes IF/ID on a taken branch or jump resolved in ID.
//  Sits between IF/ID, ID/EX and EX/MEM; keeps saturating stall and flush event counters.
// PARAMETERS
//  REG_ADDR_W   5    register-specifier width
//  CNT_W        16   width of stall_count / flush_count
// PORTS
//  clock            in   1          single system clock, rising edge
//  reset_n          in   1          asynchronous, active-low reset
//  instr_if_id      in   32         instruction in ID; rs=[25:21], rt=[20:16]
//  id_is_branch     in   1          ID holds beq/bne (compared in ID)
//  id_uses_rt       in   1          ID instruction reads rt as a source
//  id_ex_mem_read   in   1          instruction in EX is a load
//  id_ex_reg_write  in   1          instruction in EX writes a register
//  id_ex_dest       in   REG_ADDR_W destination register of EX instruction
//  ex_mem_mem_read  in   1          instruction in MEM is a load
//  ex_mem_dest      in   REG_ADDR_W destination register of MEM instruction
//  branch_taken     in   1          ID branch compare result (taken)
//  jump             in   1          ID holds j/jal
//  pc_write         out  1          PC load enable
//  if_id_write      out  1          IF/ID load enable
//  if_id_flush      out  1          synchronous clear of IF/ID at next edge
//  id_ex_bubble     out  1          zero ID/EX control fields at next edge
//  stall_active     out  1          = ~pc_write
//  stall_count      out  CNT_W      cycles with stall asserted, saturating
//  flush_count      out  CNT_W      cycles with if_id_flush asserted, saturating
// BEHAVIOUR
//  Matching, combinational; register 0 never matches:
//  - mX_rs = (X_dest==rs) && X_dest!=0
//  - mX_rt = (X_dest==rt) && X_dest!=0 && id_uses_rt
//  - mX    = mX_rs | mX_rt, for X in {ex, mem}
//  Hazard classes, in RUN:
//  - LU  = id_ex_mem_read & m_ex                          -> stall 1 cycle
//  - BL  = id_is_branch & id_ex_mem_read & m_ex           -> stall 2 cycles
//  - BA  = id_is_branch & id_ex_reg_write & ~id_ex_mem_read & m_ex -> stall 1
//  - BM  = id_is_branch & ex_mem_mem_read & m_mem         -> stall 1
//  FSM states {RUN, HOLD1}; reset state RUN:
//  - RUN,   BL                -> HOLD1, stall this cycle
//  - RUN,   LU|BA|BM (no BL)  -> RUN, stall this cycle; re-evaluate next cycle
//  - RUN,   no hazard         -> RUN, no stall
//  - HOLD1, any inputs        -> RUN, stall unconditionally
//  Stall cycle (Mealy, same cycle as hazard):
//  - pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0
//  - branch_taken and jump are ignored during any stall cycle
//  Non-stall cycle:
//  - pc_write=1, if_id_write=1, id_ex_bubble=0
//  - if_id_flush = branch_taken&id_is_branch | jump
//  - branch and jump together -> one flush, flush_count +1
//  Counters:
//  - +1 per cycle of stall / flush, updated at the clock edge
//  - hold at 2^CNT_W-1, no wrap
//  Reset (reset_n=0), asynchronous, effective immediately; legal at any time, incl. HOLD1:
//  - state=RUN, counters=0
//  - outputs forced: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, stall_active=1
//  - after reset release, the first edge evaluates from RUN
//  Register file assumed write-before-read; no WB-stage hazards are checked.
// TESTING
//  1. EX=lw $8 (id_ex_mem_read=1, dest=8), ID=add rs=8 -> 1 stall cycle, then pc_write=1, stall_count=1
//  2. EX=lw $9, ID=beq rs=3 rt=9 (id_uses_rt=1) -> stall 2 cycles via HOLD1, stall_count=2, then branch resolves
//  3. EX=addi dest=5 (reg_write), ID=bne rs=5, taken -> 1 stall, next cycle if_id_flush=1, flush_count=1
//  4. id_ex_dest=0 with mem_read=1, ID rs=0 -> no stall; jump=1 & branch_taken=1 -> single flush
//  5. reset_n low during HOLD1 -> outputs at reset values immediately; after release state RUN, counters 0
//  6. CNT_W=2, force 5 stall cycles -> stall_count saturates at 3

Source files
------------

// File: rtl/id_hazard_controller.sv
// id_hazard_controller: ID-stage hazard sequencing. Detects load-use and
// branch-operand hazards on the instruction in IF/ID, stalls PC and IF/ID,
// inserts an ID/EX bubble, flushes IF/ID on a taken branch or jump, and
// keeps saturating stall/flush event counters.
module id_hazard_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           instr_if_id,
    input  logic                  id_is_branch,
    input  logic                  id_uses_rt,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_reg_write,
    input  logic [REG_ADDR_W-1:0] id_ex_dest,
    input  logic                  ex_mem_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_mem_dest,
    input  logic                  branch_taken,
    input  logic                  jump,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        HOLD1 = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        stall_count_q, stall_count_d;
    logic [CNT_W-1:0]        flush_count_q, flush_count_d;

    logic [REG_ADDR_W-1:0]   rs, rt;
    logic                    m_ex, m_mem;
    logic                    hz_lu, hz_bl, hz_ba, hz_bm;
    logic                    stall, flush;
    logic                    unused_instr_bits;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    assign rs = REG_ADDR_W'(instr_if_id[25:21]);
    assign rt = REG_ADDR_W'(instr_if_id[20:16]);
    assign unused_instr_bits = ^{instr_if_id[31:26], instr_if_id[15:0]};

    // Source/destination matching; register 0 is hardwired and never a hazard.
    always_comb begin
        m_ex  = (id_ex_dest != '0) &&
                ((id_ex_dest == rs) || ((id_ex_dest == rt) && id_uses_rt));
        m_mem = (ex_mem_dest != '0) &&
                ((ex_mem_dest == rs) || ((ex_mem_dest == rt) && id_uses_rt));
        hz_lu = id_ex_mem_read & m_ex;
        hz_bl = id_is_branch & id_ex_mem_read & m_ex;
        hz_ba = id_is_branch & id_ex_reg_write & ~id_ex_mem_read & m_ex;
        hz_bm = id_is_branch & ex_mem_mem_read & m_mem;
    end

    // Next state, Mealy stall/flush decision and counter next values.
    always_comb begin
        state_d = RUN;
        stall   = 1'b0;
        if (state_q == HOLD1) begin
            // Second cycle of a branch-after-load stall, regardless of inputs.
            stall   = 1'b1;
            state_d = RUN;
        end else begin
            stall   = hz_lu | hz_ba | hz_bm;
            state_d = hz_bl ? HOLD1 : RUN;
        end
        // Branch/jump redirects are ignored while stalled; both at once flush once.
        flush         = ~stall & ((branch_taken & id_is_branch) | jump);
        stall_count_d = sat_inc(stall_count_q, stall);
        flush_count_d = sat_inc(flush_count_q, flush);
    end

    // Output drive; reset forces the safe stalled/bubbling pattern immediately.
    always_comb begin
        pc_write     = ~stall;
        if_id_write  = ~stall;
        id_ex_bubble = stall;
        if_id_flush  = flush;
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b0;
        end
        stall_active = ~pc_write;
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    // State and event counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule
